// File: rtl/axi4_lite_slave_regs_pkg.sv
// Shared AXI4-Lite slave definitions: response codes, FSM state types and
// the register-index range helper.
package axi4_lite_addr_map_package;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    // True when a decoded word index addresses an implemented register.
    function automatic logic idx_in_range(input logic [31:0] idx, input int unsigned reg_num);
        return idx < reg_num;
    endfunction

endpackage

// File: rtl/axi4_lite_slave_regs_wstrb_merge.sv
// Byte-strobe merge: each byte of the result comes from the new word when its
// strobe bit is set, otherwise from the old word.
module axi4_lite_wstrb_merge #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   i_old,
    input  logic [DATA_WIDTH-1:0]   i_new,
    input  logic [DATA_WIDTH/8-1:0] i_strb,
    output logic [DATA_WIDTH-1:0]   o_merged
);

    // Per-byte select between old and new data.
    always_comb begin
        o_merged = i_old;
        for (int unsigned b = 0; b < DATA_WIDTH/8; b++) begin
            if (i_strb[b]) begin
                o_merged[b*8 +: 8] = i_new[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register bank slave with independent write and read FSMs.
// AW and W may arrive in either order; out-of-range indices return SLVERR.
// Optional macro AXI4_LITE_SLAVE_WR_PULSE_EN adds a per-register write pulse.
module axi4_lite_slave_regs
    import axi4_lite_addr_map_package::*;
#(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned REG_NUM          = 16,
    parameter int unsigned LOCAL_ADDR_WIDTH = 12,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = 32'h0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           AWADDR,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [DATA_WIDTH-1:0]           WDATA,
    input  logic [DATA_WIDTH/8-1:0]         WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [ADDR_WIDTH-1:0]           ARADDR,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [DATA_WIDTH-1:0]           RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [REG_NUM*DATA_WIDTH-1:0]   reg_q
`ifdef AXI4_LITE_SLAVE_WR_PULSE_EN
    ,
    output logic [REG_NUM-1:0]              reg_wr_pulse
`endif
);

    localparam int unsigned IDX_W  = LOCAL_ADDR_WIDTH - 2;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic                  r_rst_done;
    wr_state_t             r_wr_state;
    rd_state_t             r_rd_state;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [IDX_W-1:0]      r_aw_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_regs [REG_NUM];

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    logic                  w_wr_fire;
    logic                  w_wr_valid;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_old;
    logic [DATA_WIDTH-1:0] w_wr_merged;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_rd_valid;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_unused;

    assign AWREADY = r_rst_done && (r_wr_state == WR_IDLE) && !r_aw_done;
    assign WREADY  = r_rst_done && (r_wr_state == WR_IDLE) && !r_w_done;
    assign ARREADY = r_rst_done && (r_rd_state == RD_IDLE);
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign RVALID  = r_rvalid;
    assign RRESP   = r_rresp;
    assign RDATA   = r_rdata;

    assign w_aw_hs = AWVALID && AWREADY;
    assign w_w_hs  = WVALID && WREADY;
    assign w_ar_hs = ARVALID && ARREADY;

    // A channel handshaking this cycle takes priority over its latched copy,
    // so the write can complete on the same edge as the later handshake.
    assign w_wr_idx   = w_aw_hs ? AWADDR[LOCAL_ADDR_WIDTH-1:2] : r_aw_idx;
    assign w_wr_data  = w_w_hs ? WDATA : r_wdata;
    assign w_wr_strb  = w_w_hs ? WSTRB : r_wstrb;
    assign w_wr_fire  = (r_wr_state == WR_IDLE) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    assign w_wr_valid = idx_in_range(32'(w_wr_idx), REG_NUM);
    assign w_wr_en    = w_wr_fire && w_wr_valid && (|w_wr_strb);

    assign w_rd_idx   = ARADDR[LOCAL_ADDR_WIDTH-1:2];
    assign w_rd_valid = idx_in_range(32'(w_rd_idx), REG_NUM);

    // Address bits outside the local decode window are intentionally ignored.
    assign w_unused = ^{AWADDR, ARADDR};

    // Current contents of the write target and read target registers.
    always_comb begin
        w_wr_old  = '0;
        w_rd_word = '0;
        for (int unsigned k = 0; k < REG_NUM; k++) begin
            if (32'(w_wr_idx) == k) begin
                w_wr_old = r_regs[k];
            end
            if (32'(w_rd_idx) == k) begin
                w_rd_word = r_regs[k];
            end
        end
    end

    axi4_lite_wstrb_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wstrb_merge (
        .i_old    (w_wr_old),
        .i_new    (w_wr_data),
        .i_strb   (w_wr_strb),
        .o_merged (w_wr_merged)
    );

    // Flat export of the register bank.
    for (genvar g = 0; g < REG_NUM; g++) begin : g_reg_q
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

    // Ready outputs are held low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    // Register bank update on a completed, in-range write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < REG_NUM; k++) begin
                r_regs[k] <= RESET_VAL;
            end
        end else if (w_wr_en) begin
            for (int unsigned k = 0; k < REG_NUM; k++) begin
                if (32'(w_wr_idx) == k) begin
                    r_regs[k] <= w_wr_merged;
                end
            end
        end
    end

    // Write FSM: collect AW and W in any order, then hold B until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_state <= WR_IDLE;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_idx  <= AWADDR[LOCAL_ADDR_WIDTH-1:2];
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= WDATA;
                        r_wstrb  <= WSTRB;
                        r_w_done <= 1'b1;
                    end
                    if (w_wr_fire) begin
                        r_bvalid   <= 1'b1;
                        r_bresp    <= w_wr_valid ? RESP_OKAY : RESP_SLVERR;
                        r_wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        r_bvalid   <= 1'b0;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: r_wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read FSM: capture data on AR handshake, hold R until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_state <= RD_IDLE;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata    <= w_rd_valid ? w_rd_word : '0;
                        r_rresp    <= w_rd_valid ? RESP_OKAY : RESP_SLVERR;
                        r_rvalid   <= 1'b1;
                        r_rd_state <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (RREADY) begin
                        r_rvalid   <= 1'b0;
                        r_rd_state <= RD_IDLE;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

`ifdef AXI4_LITE_SLAVE_WR_PULSE_EN
    logic [REG_NUM-1:0] r_wr_pulse;

    // One-cycle pulse per register, aligned with the first cycle of new reg_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_wr_en) begin
                for (int unsigned k = 0; k < REG_NUM; k++) begin
                    if (32'(w_wr_idx) == k) begin
                        r_wr_pulse[k] <= 1'b1;
                    end
                end
            end
        end
    end

    assign reg_wr_pulse = r_wr_pulse;
`else
    // No write pulse output; the write enable only drives the register bank.
`endif

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed testbench for axi4_lite_slave_regs with a response scoreboard.
module tb_axi4_lite_slave_regs;
    import axi4_lite_addr_map_package::*;

    localparam int unsigned NREG = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [NREG*32-1:0] reg_q;
`ifdef AXI4_LITE_SLAVE_WR_PULSE_EN
    logic [NREG-1:0] reg_wr_pulse;
`endif

    always #5 clk = ~clk;

    axi4_lite_slave_regs #(
        .ADDR_WIDTH       (32),
        .DATA_WIDTH       (32),
        .REG_NUM          (NREG),
        .LOCAL_ADDR_WIDTH (12),
        .RESET_VAL        (32'h0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .reg_q   (reg_q)
`ifdef AXI4_LITE_SLAVE_WR_PULSE_EN
        ,
        .reg_wr_pulse (reg_wr_pulse)
`endif
    );

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    logic [1:0]  q_b[$];
    logic [33:0] q_r[$];
    logic [31:0] model [NREG];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_of(input int unsigned k);
        return reg_q[k*32 +: 32];
    endfunction

    function automatic logic [NREG*32-1:0] model_flat();
        logic [NREG*32-1:0] f;
        for (int unsigned k = 0; k < NREG; k++) f[k*32 +: 32] = model[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int unsigned k = 0; k < NREG; k++) model[k] = 32'h0;
    endtask

    // Expected write response, and the model register update it implies.
    task automatic push_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int unsigned idx;
        idx = 32'(addr[11:2]);
        if (idx < NREG) begin
            for (int unsigned b = 0; b < 4; b++)
                if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            q_b.push_back(RESP_OKAY);
        end else begin
            q_b.push_back(RESP_SLVERR);
        end
    endtask

    task automatic push_read(input logic [31:0] addr);
        int unsigned idx;
        idx = 32'(addr[11:2]);
        if (idx < NREG) q_r.push_back({RESP_OKAY, model[idx]});
        else            q_r.push_back({RESP_SLVERR, 32'h0});
    endtask

    task automatic pop_b(input string tag);
        logic [1:0] e;
        check({tag, "_bvalid"}, 64'(BVALID), 64'(1));
        check({tag, "_sb_b"}, 64'(q_b.size() != 0), 64'(1));
        if (q_b.size() != 0) begin
            e = q_b.pop_front();
            check({tag, "_bresp"}, 64'(BRESP), 64'(e));
        end
    endtask

    task automatic pop_r(input string tag);
        logic [33:0] e;
        check({tag, "_rvalid"}, 64'(RVALID), 64'(1));
        check({tag, "_sb_r"}, 64'(q_r.size() != 0), 64'(1));
        if (q_r.size() != 0) begin
            e = q_r.pop_front();
            check({tag, "_rdata"}, 64'(RDATA), 64'(e[31:0]));
            check({tag, "_rresp"}, 64'(RRESP), 64'(e[33:32]));
        end
    endtask

    task automatic b_ack(input string tag);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        check({tag, "_bvalid_clr"}, 64'(BVALID), 64'(0));
    endtask

    task automatic r_ack(input string tag);
        RREADY = 1'b1;
        step();
        RREADY = 1'b0;
        check({tag, "_rvalid_clr"}, 64'(RVALID), 64'(0));
    endtask

    task automatic write_same(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input string tag);
        check({tag, "_awready"}, 64'(AWREADY), 64'(1));
        check({tag, "_wready"}, 64'(WREADY), 64'(1));
        AWADDR = addr; AWVALID = 1'b1;
        WDATA = data; WSTRB = strb; WVALID = 1'b1;
        push_write(addr, data, strb);
        step();
        AWVALID = 1'b0; WVALID = 1'b0;
        pop_b(tag);
        b_ack(tag);
    endtask

    task automatic read(input logic [31:0] addr, input string tag);
        check({tag, "_arready"}, 64'(ARREADY), 64'(1));
        ARADDR = addr; ARVALID = 1'b1;
        push_read(addr);
        step();
        ARVALID = 1'b0;
        pop_r(tag);
        r_ack(tag);
    endtask

    initial begin
        logic [31:0] hold_rdata;
        logic [1:0]  hold_rresp;
        logic [1:0]  hold_bresp;

        rst = 1'b0;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        model_reset();
        #1;
        step();
        step();

        // Reset state
        check("rst_awready", 64'(AWREADY), 64'(0));
        check("rst_wready", 64'(WREADY), 64'(0));
        check("rst_arready", 64'(ARREADY), 64'(0));
        check("rst_bvalid", 64'(BVALID), 64'(0));
        check("rst_rvalid", 64'(RVALID), 64'(0));
        check("rst_rdata", 64'(RDATA), 64'(0));
        check("rst_regq", 64'(reg_q != model_flat()), 64'(0));
        rst = 1'b1;
        #1;
        check("rel_awready_pre", 64'(AWREADY), 64'(0));
        step();
        check("rel_arready", 64'(ARREADY), 64'(1));

        // Basic write then read
        write_same(32'h0000_0008, 32'hDEADBEEF, 4'hF, "wr08");
        check("wr08_regq", 64'(reg_of(2)), 64'h0000_0000_DEAD_BEEF);
        read(32'h0000_0008, "rd08");

        // W three cycles ahead of AW, partial strobe
        WDATA = 32'h12345678; WSTRB = 4'b0101; WVALID = 1'b1;
        push_write(32'h0000_0004, 32'h12345678, 4'b0101);
        check("wfirst_wready", 64'(WREADY), 64'(1));
        step();
        WVALID = 1'b0;
        check("wfirst_wready_drop", 64'(WREADY), 64'(0));
        step();
        step();
        check("wfirst_bvalid_early", 64'(BVALID), 64'(0));
        check("wfirst_awready", 64'(AWREADY), 64'(1));
        AWADDR = 32'h0000_0004; AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        pop_b("wfirst");
        check("wfirst_regq", 64'(reg_of(1)), 64'h0000_0000_0034_0078);
        b_ack("wfirst");

        // Out-of-range index
        write_same(32'h0000_0040, 32'hFFFFFFFF, 4'hF, "wr40");
        check("wr40_regq", 64'(reg_q != model_flat()), 64'(0));
        read(32'h0000_0040, "rd40");

        // Last register, low address bits ignored, zero strobe
        write_same(32'h1000_003C, 32'hCAFEF00D, 4'b1100, "wr3c");
        read(32'h0000_003F, "rd3f");
        write_same(32'h0000_0008, 32'h0, 4'h0, "wrzero");
        read(32'h0000_000A, "rd0a");

        // Backpressure on both response channels
        AWADDR = 32'h0000_0010; WDATA = 32'h0BADF00D; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 32'h0000_0008; ARVALID = 1'b1;
        push_read(32'h0000_0008);
        push_write(32'h0000_0010, 32'h0BADF00D, 4'hF);
        hold_rdata = model[2];
        hold_rresp = RESP_OKAY;
        hold_bresp = RESP_OKAY;
        step();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", 64'(BVALID), 64'(1));
            check("bp_bresp", 64'(BRESP), 64'(hold_bresp));
            check("bp_rvalid", 64'(RVALID), 64'(1));
            check("bp_rdata", 64'(RDATA), 64'(hold_rdata));
            check("bp_rresp", 64'(RRESP), 64'(hold_rresp));
            check("bp_readies", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
            step();
        end
        pop_b("bp");
        pop_r("bp");
        BREADY = 1'b1; RREADY = 1'b1;
        step();
        BREADY = 1'b0; RREADY = 1'b0;
        check("bp_done", 64'({BVALID, RVALID}), 64'(0));
        check("bp_regq", 64'(reg_of(4)), 64'h0000_0000_0BAD_F00D);

        // Same-edge write and read of one register
        AWADDR = 32'h0000_000C; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 32'h0000_000C; ARVALID = 1'b1;
        push_read(32'h0000_000C);
        push_write(32'h0000_000C, 32'hA5A5A5A5, 4'hF);
        step();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
`ifdef AXI4_LITE_SLAVE_WR_PULSE_EN
        check("pulse_on", 64'(reg_wr_pulse), 64'(16'h0008));
`endif
        pop_r("same");
        pop_b("same");
        BREADY = 1'b1; RREADY = 1'b1;
        step();
        BREADY = 1'b0; RREADY = 1'b0;
`ifdef AXI4_LITE_SLAVE_WR_PULSE_EN
        check("pulse_off", 64'(reg_wr_pulse), 64'(0));
`endif
        read(32'h0000_000C, "rd0c");

        // Reset while responses are pending
        AWADDR = 32'h0000_0014; WDATA = 32'h11111111; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 32'h0000_000C; ARVALID = 1'b1;
        push_read(32'h0000_000C);
        push_write(32'h0000_0014, 32'h11111111, 4'hF);
        step();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        pop_b("pre_rst");
        pop_r("pre_rst");
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valids", 64'({BVALID, RVALID}), 64'(0));
        check("mid_rst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
        model_reset();
        check("mid_rst_regq", 64'(reg_q != model_flat()), 64'(0));
        step();
        rst = 1'b1;
        step();
        write_same(32'h0000_0008, 32'h5A5A5A5A, 4'hF, "post_wr");
        read(32'h0000_0008, "post_rd08");
        read(32'h0000_000C, "post_rd0c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
- Generic AXI4-Lite responder: a bank of REG_NUM memory-mapped 32-bit registers.
- Sits on one slave port of the SoC AXI4-Lite interconnect and terminates write/read transactions routed by the decoder.
- Register contents are exported to peripheral hardware as flat outputs.
- Independent write and read FSMs; AW and W accepted in either order.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; must be 32.
- REG_NUM, 16, number of registers (1..256).
- LOCAL_ADDR_WIDTH, 12, low address bits decoded locally; upper bits ignored (interconnect already selected this slave).
- RESET_VAL, 32'h0, reset value of every register.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- AWADDR  in  ADDR_WIDTH  write address
- AWVALID  in  1  / AWREADY  out  1
- WDATA  in  DATA_WIDTH  / WSTRB  in  DATA_WIDTH/8
- WVALID  in  1  / WREADY  out  1
- BRESP  out  2  / BVALID  out  1  / BREADY  in  1
- ARADDR  in  ADDR_WIDTH  / ARVALID  in  1  / ARREADY  out  1
- RDATA  out  DATA_WIDTH  / RRESP  out  2  / RVALID  out  1  / RREADY  in  1
- reg_q  out  REG_NUM*DATA_WIDTH  register contents; register k occupies bits [k*32 +: 32]

Behaviour:
- Reset (rst low, async):
  - registers = RESET_VAL.
  - BVALID, RVALID = 0; RDATA = 0; BRESP, RRESP = 0.
  - AWREADY, WREADY, ARREADY = 0; they rise at the first clk edge after rst deasserts, via a registered rst_done flag.
  - Any in-flight transaction is discarded with no response.
- Index decode: idx = addr[LOCAL_ADDR_WIDTH-1:2]. addr[1:0] is ignored.
  - Valid if idx < REG_NUM.
  - Otherwise invalid: response SLVERR (2'b10), write dropped, RDATA = 0.
- Write FSM states: WR_IDLE, WR_RESP.
  - WR_IDLE: AWREADY = !aw_done; WREADY = !w_done.
  - Each handshake latches its channel (address or data+strobe) and sets its done flag.
  - The cycle the second of the two handshakes completes (or both together): at that clk edge the selected register is updated, BVALID rises, and the state goes to WR_RESP.
  - Write latency: BVALID 1 cycle after the last of AW/W.
  - Per-byte write: byte b is written only if WSTRB[b] = 1. WSTRB = 0 on a valid address writes nothing and returns OKAY.
  - WR_RESP: AWREADY = WREADY = 0; BVALID and BRESP held stable until BREADY. On the BREADY handshake edge: BVALID = 0, flags cleared, state = WR_IDLE. Earliest next acceptance is the following cycle.
- Read FSM states: RD_IDLE, RD_RESP.
  - RD_IDLE: ARREADY = 1. On the AR handshake edge: RDATA and RRESP are latched, RVALID = 1, state = RD_RESP.
  - Read latency: 1 cycle.
  - RD_RESP: ARREADY = 0; RDATA, RRESP and RVALID held stable until RREADY. The handshake edge returns the state to RD_IDLE.
- Simultaneous read and write to the same register on the same edge: the read returns the pre-write value.
- Write and read FSMs fully independent; both may hold responses concurrently.
- reg_q reflects the new value the cycle after the write edge.

Optional Feature:
- Macro: AXI4_LITE_SLAVE_WR_PULSE_EN.
- Defined: adds output reg_wr_pulse [REG_NUM-1:0], registered.
  - Bit k is high for exactly one cycle, coincident with the first cycle reg_q shows the new value, when register k takes a valid write with any WSTRB bit set.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- axi4_lite_addr_map_package gains:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - wr_state_t {WR_IDLE, WR_RESP} and rd_state_t {RD_IDLE, RD_RESP}.
- Sub-module axi4_lite_wstrb_merge (combinational): old word, new word and strobe in; merged word out. Reused by future memory slaves.

Test Plan:
- Reset release, then AW+W same cycle to 0x008, WDATA = 32'hDEADBEEF, WSTRB = 4'hF -> BVALID next cycle with BRESP = 00; reg_q[2] = 32'hDEADBEEF; AR to 0x008 -> RVALID 1 cycle later with RDATA = DEADBEEF, RRESP = 00.
- W sent 3 cycles before AW (addr 0x004, data 32'h12345678, WSTRB = 4'b0101) -> WREADY drops after the W handshake; BVALID 1 cycle after AW; reg_q[1] = 32'h00340078.
- Write to 0x040 with REG_NUM = 16 -> BRESP = 10, no register changes; read of 0x040 -> RDATA = 0, RRESP = 10.
- Backpressure: BREADY/RREADY held low 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA stay stable; AWREADY, WREADY and ARREADY stay 0 until the handshake.
- Same-edge write 32'hA5A5A5A5 and read to 0x00C, old value 0 -> RDATA = 0; a subsequent read returns A5A5A5A5. With AXI4_LITE_SLAVE_WR_PULSE_EN defined, reg_wr_pulse[3] is high for exactly one cycle.
- rst asserted while BVALID = 1 -> BVALID, RVALID and the READY outputs drop immediately; registers return to RESET_VAL; normal operation resumes after release.
